// File: rtl/spi_apb_pkg.sv
// Shared types and constants for the SPI APB master bridge.
// FSM state encoding, SPI register map and default bus widths.
package spi_apb_pkg;

  localparam int DEF_ADDR_W         = 3;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  localparam logic [2:0] ADDR_CR1 = 3'b000;
  localparam logic [2:0] ADDR_CR2 = 3'b001;
  localparam logic [2:0] ADDR_BR  = 3'b010;
  localparam logic [2:0] ADDR_SR  = 3'b011;
  localparam logic [2:0] ADDR_DR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/spi_apb_wait_timer.sv
// Saturating ACCESS-phase wait counter for the bridge timeout.
// The top instantiates it only when SPI_APB_TIMEOUT_EN is defined.
module spi_apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Counter saturates at LIMIT so it can never wrap back below the threshold
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/spi_apb_master_bridge.sv
// Command/response to APB requester driving the SPI APB slave port.
// Optional ACCESS-phase timeout abort enabled by defining SPI_APB_TIMEOUT_EN.
module spi_apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i,
  input  logic              PSLVERR_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_apb_master_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  apb_state_t state, state_next;
  logic       cmd_accept;
  logic       complete;
  logic       abort;

  assign cmd_accept = cmd_valid_i && cmd_ready_o;
  assign complete   = (state == ACCESS) && PREADY_i;

`ifdef SPI_APB_TIMEOUT_EN
  logic wait_expired;

  spi_apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESET_n(PRESET_n),
    .clear   (state == SETUP),
    .inc     ((state == ACCESS) && !PREADY_i),
    .expired (wait_expired)
  );

  assign abort = (state == ACCESS) && !PREADY_i && wait_expired;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A command accepted at completion chains straight into SETUP with no IDLE gap
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (complete) begin
          state_next = cmd_accept ? SETUP : IDLE;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    PSEL_o      = 1'b0;
    PENABLE_o   = 1'b0;
    busy_o      = (state != IDLE);
    cmd_ready_o = (state == IDLE) || complete;
    unique case (state)
      SETUP:  PSEL_o = 1'b1;
      ACCESS: begin
        PSEL_o    = 1'b1;
        PENABLE_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      PWRITE_o <= 1'b0;
      PADDR_o  <= '0;
      PWDATA_o <= '0;
    end else if (cmd_accept) begin
      PWRITE_o <= cmd_write_i;
      PADDR_o  <= cmd_addr_i;
      PWDATA_o <= cmd_wdata_i;
    end
  end

  // Read data and error hold between completions; only the valid strobe pulses
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= complete || abort;
      if (complete) begin
        rsp_rdata_o   <= PWRITE_o ? '0 : PRDATA_i;
        rsp_err_o     <= PSLVERR_i;
        rsp_timeout_o <= 1'b0;
      end else if (abort) begin
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_apb_master_bridge.sv
// Self-checking bench for spi_apb_master_bridge: vector table, hand sequences
// and randomized traffic against a command-level register-file model.
module tb_spi_apb_master_bridge;
  import spi_apb_pkg::*;

  localparam int TMO = DEF_TIMEOUT_CYCLES;

  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_write_i = 1'b0;
  logic [2:0] cmd_addr_i = '0;
  logic [7:0] cmd_wdata_i = '0;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o;
  logic       rsp_timeout_o;
  logic       busy_o;
  logic       PSEL_o;
  logic       PENABLE_o;
  logic       PWRITE_o;
  logic [2:0] PADDR_o;
  logic [7:0] PWDATA_o;
  logic [7:0] PRDATA_i = '0;
  logic       PREADY_i = 1'b0;
  logic       PSLVERR_i = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [7:0] slave_mem [8];
  logic [7:0] ref_mem [8];

  typedef struct {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [5];

  spi_apb_master_bridge dut (
    .PCLK         (PCLK),
    .PRESET_n     (PRESET_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o       (busy_o),
    .PSEL_o       (PSEL_o),
    .PENABLE_o    (PENABLE_o),
    .PWRITE_o     (PWRITE_o),
    .PADDR_o      (PADDR_o),
    .PWDATA_o     (PWDATA_o),
    .PRDATA_i     (PRDATA_i),
    .PREADY_i     (PREADY_i),
    .PSLVERR_i    (PSLVERR_i)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete transfer from an idle bridge, checked cycle by cycle
  task automatic applyStimulus(input vec_t v, input bit use_mem);
    int         en_cycles;
    logic [7:0] prd;
    @(negedge PCLK);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    PREADY_i    = 1'b0;
    #1 checkOutput("idle_ready", cmd_ready_o, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 3'($urandom);
    cmd_wdata_i = 8'($urandom);
    checkOutput("setup_psel", PSEL_o, 1);
    checkOutput("setup_penable", PENABLE_o, 0);
    checkOutput("setup_paddr", PADDR_o, v.addr);
    checkOutput("setup_pwrite", PWRITE_o, v.write);
    checkOutput("setup_pwdata", PWDATA_o, v.wdata);
    #1 checkOutput("setup_not_ready", cmd_ready_o, 0);
    @(posedge PCLK);
    en_cycles = 0;
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge PCLK);
      if (PSEL_o === 1'b1 && PENABLE_o === 1'b1) en_cycles++;
      checkOutput("access_paddr", PADDR_o, v.addr);
      if (i == v.waits) begin
        prd = use_mem ? slave_mem[PADDR_o] : v.prdata;
        if (use_mem && PWRITE_o === 1'b1) slave_mem[PADDR_o] = PWDATA_o;
        PREADY_i  = 1'b1;
        PRDATA_i  = prd;
        PSLVERR_i = v.slverr;
      end else begin
        PREADY_i  = 1'b0;
        PRDATA_i  = 8'($urandom);
        PSLVERR_i = 1'($urandom);
      end
      #1 checkOutput("ready_comb", cmd_ready_o, (i == v.waits) ? 1 : 0);
      @(posedge PCLK);
    end
    checkOutput("enable_cycles", en_cycles, v.waits + 1);
    @(negedge PCLK);
    PREADY_i  = 1'b0;
    PSLVERR_i = 1'b0;
    checkOutput("rsp_valid", rsp_valid_o, 1);
    checkOutput("rsp_rdata", rsp_rdata_o, v.exp_rdata);
    checkOutput("rsp_err", rsp_err_o, v.exp_err);
    checkOutput("rsp_timeout", rsp_timeout_o, 0);
    checkOutput("end_psel", PSEL_o, 0);
    checkOutput("end_busy", busy_o, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("rsp_pulse_end", rsp_valid_o, 0);
    checkOutput("rsp_rdata_hold", rsp_rdata_o, v.exp_rdata);
    checkOutput("rsp_err_hold", rsp_err_o, v.exp_err);
  endtask

  initial begin
    vec_t rv;
    int   acc;
    int   pulses;
    bit   done;

    vecs[0] = '{1'b1, ADDR_CR1, 8'h50, 0,  8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, ADDR_BR,  8'h00, 3,  8'h23, 1'b0, 8'h23, 1'b0};
    vecs[2] = '{1'b0, ADDR_DR,  8'h11, 1,  8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[3] = '{1'b0, ADDR_SR,  8'h00, 15, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, ADDR_CR2, 8'hC3, 2,  8'hEE, 1'b1, 8'h00, 1'b1};

    for (int i = 0; i < 8; i++) begin
      slave_mem[i] = 8'(i * 17);
      ref_mem[i]   = 8'(i * 17);
    end

    #1;
    checkOutput("reset_psel", PSEL_o, 0);
    checkOutput("reset_penable", PENABLE_o, 0);
    checkOutput("reset_paddr", PADDR_o, 0);
    checkOutput("reset_pwdata", PWDATA_o, 0);
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    repeat (2) @(negedge PCLK);
    PRESET_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 1'b0);

    $display("[TB] back-to-back write DR then read SR");
    pulses = 0;
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = ADDR_DR; cmd_wdata_i = 8'hA5;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_write_i = 1'b0; cmd_addr_i = ADDR_SR; cmd_wdata_i = 8'h00;
    checkOutput("b2b_setup1_psel", PSEL_o, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("b2b_access1_paddr", PADDR_o, ADDR_DR);
    checkOutput("b2b_access1_pwdata", PWDATA_o, 8'hA5);
    PREADY_i = 1'b1; PSLVERR_i = 1'b0; PRDATA_i = 8'h99;
    #1 checkOutput("b2b_ready", cmd_ready_o, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0; PREADY_i = 1'b0;
    if (rsp_valid_o === 1'b1) pulses++;
    checkOutput("b2b_psel_kept", PSEL_o, 1);
    checkOutput("b2b_setup2_penable", PENABLE_o, 0);
    checkOutput("b2b_paddr2", PADDR_o, ADDR_SR);
    checkOutput("b2b_pwrite2", PWRITE_o, 0);
    checkOutput("b2b_rsp1_rdata", rsp_rdata_o, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    if (rsp_valid_o === 1'b1) pulses++;
    checkOutput("b2b_access2", PENABLE_o, 1);
    PREADY_i = 1'b1; PRDATA_i = 8'h81;
    @(posedge PCLK);
    @(negedge PCLK);
    PREADY_i = 1'b0;
    if (rsp_valid_o === 1'b1) pulses++;
    checkOutput("b2b_rsp2_rdata", rsp_rdata_o, 8'h81);
    checkOutput("b2b_end_psel", PSEL_o, 0);
    checkOutput("b2b_pulses", pulses, 2);

`ifdef SPI_APB_TIMEOUT_EN
    $display("[TB] timeout abort");
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = ADDR_SR;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0; PREADY_i = 1'b0;
    @(posedge PCLK);
    acc = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (PSEL_o === 1'b1 && PENABLE_o === 1'b1) begin
        acc++;
        if (acc == TMO) begin
          cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = ADDR_CR1;
        end
      end else begin
        done = 1'b1;
      end
    end
    cmd_valid_i = 1'b0;
    checkOutput("tmo_bound", done, 1);
    checkOutput("tmo_access_cycles", acc, TMO);
    checkOutput("tmo_psel", PSEL_o, 0);
    checkOutput("tmo_rsp_valid", rsp_valid_o, 1);
    checkOutput("tmo_rsp_err", rsp_err_o, 1);
    checkOutput("tmo_rsp_timeout", rsp_timeout_o, 1);
    checkOutput("tmo_rsp_rdata", rsp_rdata_o, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("tmo_no_accept", PSEL_o, 0);
    checkOutput("tmo_rsp_end", rsp_valid_o, 0);
`else
    $display("[TB] no timeout: long wait");
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = ADDR_SR;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0; PREADY_i = 1'b0;
    repeat (100) @(negedge PCLK);
    checkOutput("notmo_psel", PSEL_o, 1);
    checkOutput("notmo_penable", PENABLE_o, 1);
    checkOutput("notmo_rsp_valid", rsp_valid_o, 0);
    PREADY_i = 1'b1; PRDATA_i = 8'h42;
    @(posedge PCLK);
    @(negedge PCLK);
    PREADY_i = 1'b0;
    checkOutput("notmo_rsp", rsp_valid_o, 1);
    checkOutput("notmo_rdata", rsp_rdata_o, 8'h42);
    checkOutput("notmo_timeout", rsp_timeout_o, 0);
`endif

    $display("[TB] reset during ACCESS");
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = ADDR_CR2; cmd_wdata_i = 8'h77;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("rst_pre_access", PENABLE_o, 1);
    #2 PRESET_n = 1'b0;
    PREADY_i = 1'b1;
    #1;
    checkOutput("rst_psel", PSEL_o, 0);
    checkOutput("rst_penable", PENABLE_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    PREADY_i = 1'b0;
    #1 checkOutput("rst_ready_after", cmd_ready_o, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("rst_no_rsp", rsp_valid_o, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 24; n++) begin
      rv.write  = 1'($urandom);
      rv.addr   = 3'($urandom);
      rv.wdata  = 8'($urandom);
      rv.waits  = int'($urandom_range(0, 6));
      rv.prdata = 8'h00;
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.exp_err = rv.slverr;
      if (rv.write) begin
        rv.exp_rdata = 8'h00;
        ref_mem[rv.addr] = rv.wdata;
      end else begin
        rv.exp_rdata = ref_mem[rv.addr];
      end
      applyStimulus(rv, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/spi_apb_master_bridge.md
Name: spi_apb_master_bridge

Overview:
- APB requester that drives the SPI peripheral's APB slave port from a simple command/response interface.
- Converts one command (read or write, 3-bit address, 8-bit data) into a compliant APB SETUP/ACCESS sequence.
- Honours PREADY wait states and returns read data plus error status.
- Sits between the SoC-side control logic (or a test sequencer) and the SPI APB slave interface.

Parameters:
ADDR_W, 3, APB address width (PADDR_o and cmd_addr_i)
DATA_W, 8, APB data width (PWDATA_o, PRDATA_i, cmd_wdata_i, rsp_rdata_o)
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for PREADY_i (used only with SPI_APB_TIMEOUT_EN); must be ≥2

Ports:
PCLK  input  1  APB clock
PRESET_n  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o at PCLK rise
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  target register address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  one-cycle pulse: transfer finished
rsp_rdata_o  output  DATA_W  read data (0 for writes); valid with rsp_valid_o
rsp_err_o  output  1  PSLVERR_i sampled at completion, or timeout
rsp_timeout_o  output  1  completion was a timeout abort
busy_o  output  1  transfer in SETUP or ACCESS
PSEL_o  output  1  APB select
PENABLE_o  output  1  APB enable
PWRITE_o  output  1  APB direction
PADDR_o  output  ADDR_W  APB address
PWDATA_o  output  DATA_W  APB write data
PRDATA_i  input  DATA_W  APB read data
PREADY_i  input  1  APB ready
PSLVERR_i  input  1  APB slave error

Behaviour:
- Reset: PRESET_n asynchronous, active-low; clock PCLK.
- All registered outputs reset to 0: PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, rsp_*.
- State returns to IDLE on reset. A reset mid-transfer drops PSEL_o/PENABLE_o immediately and produces no response.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready_o = 1.
  - On accept: register write/addr/wdata onto PWRITE_o/PADDR_o/PWDATA_o, go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL_o = 1, PENABLE_o = 0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL_o = 1, PENABLE_o = 1; PADDR_o/PWRITE_o/PWDATA_o held stable.
  - Wait while PREADY_i = 0.
- Completion (ACCESS && PREADY_i):
  - Next cycle rsp_valid_o = 1 for one cycle.
  - rsp_rdata_o = PRDATA_i if read, 0 if write.
  - rsp_err_o = PSLVERR_i; rsp_timeout_o = 0.
- Back-to-back commands:
  - cmd_ready_o = (IDLE) || (ACCESS && PREADY_i). cmd_ready_o is combinational on PREADY_i.
  - If a command is accepted at completion: go directly to SETUP (PSEL_o stays 1, PENABLE_o drops to 0) and latch the new command.
  - Otherwise go to IDLE with PSEL_o = 0, PENABLE_o = 0.
- Minimum transfer: 2 cycles (SETUP + 1 ACCESS). Against the SPI slave interface (registered PREADY) a transfer takes 3 cycles (one wait state).
- Response and acceptance are independent: rsp_valid_o may coincide with the SETUP cycle of the next command.
- rsp_rdata_o/rsp_err_o hold their last values until the next completion. rsp_valid_o is 0 otherwise.
- busy_o = (state != IDLE).
- cmd_valid_i while not ready: ignored. No buffering; the command must be held by the requester.

Optional Feature:
- Macro: SPI_APB_TIMEOUT_EN.
- Defined:
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY_i = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with PREADY_i still 0: abort.
  - Abort: PSEL_o and PENABLE_o go to 0 next cycle, state → IDLE, rsp_valid_o = 1, rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - PREADY_i = 1 in the same cycle as the limit is reached: normal completion wins.
  - No command is accepted in the abort cycle.
- Not defined: no counter; waits indefinitely; rsp_timeout_o tied 0.

Decomposition:
- Package spi_apb_pkg:
  - FSM state typedef (IDLE/SETUP/ACCESS).
  - SPI register address constants: CR1 = 3'b000, CR2 = 3'b001, BR = 3'b010, SR = 3'b011, DR = 3'b101.
  - Default widths.
- One natural sub-module: spi_apb_wait_timer. It holds the saturating wait counter with clear/inc inputs and an expired output. It is instantiated only under SPI_APB_TIMEOUT_EN.

Test Plan:
- Write CR1: cmd write, addr 0, data 8'h50, PREADY_i = 1 in the first ACCESS cycle. Expect:
  - PSEL_o = 1 and PENABLE_o = 0 for 1 cycle, then PENABLE_o = 1 for 1 cycle.
  - PADDR_o = 0, PWDATA_o = 8'h50.
  - rsp_valid_o pulse with rsp_err_o = 0, rsp_rdata_o = 0.
- Read BR with 3 wait states: PRDATA_i = 8'h23 when PREADY_i rises. Expect PENABLE_o held for 4 cycles, address stable throughout, and rsp_rdata_o = 8'h23.
- Back-to-back: write DR = 8'hA5, then read SR queued with cmd_valid_i high. Expect:
  - No IDLE cycle between the transfers (PSEL_o stays 1 across the boundary).
  - Second PADDR_o = 3'b011.
  - Two rsp_valid_o pulses.
- Slave error: PSLVERR_i = 1 with PREADY_i (SPI transfer in progress). Expect rsp_err_o = 1, rsp_timeout_o = 0.
- Timeout (macro on, TIMEOUT_CYCLES = 16), PREADY_i held 0. Expect:
  - Abort after 16 ACCESS cycles: PSEL_o = 0.
  - rsp_valid_o with rsp_err_o = 1, rsp_timeout_o = 1.
  - Macro off: PSEL_o still 1 after 100 cycles.
- Reset mid-ACCESS: assert PRESET_n = 0 asynchronously. Expect PSEL_o, PENABLE_o and rsp_valid_o at 0 immediately, and cmd_ready_o = 1 after release.
